// File: rtl/rram_program_ctrl.sv
// Program-and-verify controller for one 32-cell RRAM row: verifies each column,
// pulses mismatched cells up to MAX_RETRY times, and records cells that never converge.
module rram_program_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PULSE_CYCLES  = 4,
  parameter int MAX_RETRY     = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [31:0] data_register,
  input  logic [4:0]  register_add,
  input  logic        SENSE,
  output logic [4:0]  ROW,
  output logic [4:0]  COL,
  output logic        READ_EN,
  output logic        SET_PULSE,
  output logic        RESET_PULSE,
  output logic        BUSY,
  output logic        DONE,
  output logic        FAIL,
  output logic [31:0] FAIL_MAP
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_VERIFY = 2'd1;
  localparam logic [1:0] S_PULSE  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  // One timer serves both settle and pulse phases, sized for the longer of the two.
  localparam int TMAX = (SETTLE_CYCLES > PULSE_CYCLES) ? SETTLE_CYCLES : PULSE_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int RW   = $clog2(MAX_RETRY + 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] PULSE_LAST  = TW'(PULSE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);

  logic [1:0]    state_q, state_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [4:0]    row_q, row_d;
  logic [4:0]    col_q, col_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          fail_q, fail_d;
  logic [31:0]   fmap_q, fmap_d;
  logic          tgt_bit;
  logic          mismatch;

  assign tgt_bit  = shadow_q[col_q];
  assign mismatch = (SENSE != tgt_bit);

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    row_d    = row_q;
    col_d    = col_q;
    tmr_d    = tmr_q;
    retry_d  = retry_q;
    fail_d   = fail_q;
    fmap_d   = fmap_q;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          shadow_d = data_register;
          row_d    = register_add;
          col_d    = 5'd0;
          retry_d  = '0;
          tmr_d    = '0;
          fail_d   = 1'b0;
          fmap_d   = '0;
          state_d  = S_VERIFY;
        end
      end
      S_VERIFY: begin
        if (tmr_q == SETTLE_LAST) begin
          tmr_d = '0;
          if (mismatch && (retry_q < RETRY_MAX)) begin
            state_d = S_PULSE;
          end else begin
            // Out of retries with the cell still wrong: record it and move on.
            if (mismatch) fmap_d[col_q] = 1'b1;
            if (col_q == 5'd31) begin
              state_d = S_FINISH;
              fail_d  = |fmap_d;
            end else begin
              col_d   = col_q + 5'd1;
              retry_d = '0;
            end
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_PULSE: begin
        if (tmr_q == PULSE_LAST) begin
          tmr_d   = '0;
          retry_d = retry_q + 1'b1;
          state_d = S_VERIFY;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      tmr_q   <= '0;
      retry_q <= '0;
      fail_q  <= 1'b0;
      fmap_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      tmr_q   <= tmr_d;
      retry_q <= retry_d;
      fail_q  <= fail_d;
      fmap_q  <= fmap_d;
    end
  end

  // The target word is pure data and is always overwritten before use.
  always_ff @(posedge CLK) begin
    shadow_q <= shadow_d;
  end

  assign ROW         = row_q;
  assign COL         = col_q;
  assign READ_EN     = (state_q == S_VERIFY);
  assign SET_PULSE   = (state_q == S_PULSE) &&  tgt_bit;
  assign RESET_PULSE = (state_q == S_PULSE) && !tgt_bit;
  assign BUSY        = (state_q != S_IDLE);
  assign DONE        = (state_q == S_FINISH);
  assign FAIL        = fail_q;
  assign FAIL_MAP    = fmap_q;

endmodule

// File: tb/tb_rram_program_ctrl.sv
// Bench for rram_program_ctrl: a cell model that converges after a chosen number of
// correct-polarity pulses, and a per-cycle expected trace built from the column cost rules.
module tb_rram_program_ctrl;
  localparam int S = 2;
  localparam int P = 4;
  localparam int M = 3;

  logic        CLK = 1'b0;
  logic        RST, START, SENSE;
  logic [31:0] data_register;
  logic [4:0]  register_add;
  logic [4:0]  ROW, COL;
  logic        READ_EN, SET_PULSE, RESET_PULSE, BUSY, DONE, FAIL;
  logic [31:0] FAIL_MAP;

  int checks = 0;
  int errors = 0;

  int          need[32];
  int          pc[32];
  logic [31:0] tgt;
  int          cyc, done_seen, done_idx, set_bursts, reset_bursts, set_cyc, set_col;
  logic        prev_set, prev_rst;

  typedef struct packed {
    logic [4:0]  row;
    logic [4:0]  col;
    logic        rd;
    logic        st;
    logic        rs;
    logic        busy;
    logic        done;
    logic        fail;
    logic [31:0] fmap;
  } obs_t;

  obs_t exp_q[$];
  bit   ccol_q[$];

  rram_program_ctrl #(.SETTLE_CYCLES(S), .PULSE_CYCLES(P), .MAX_RETRY(M)) dut (
    .CLK(CLK), .RST(RST), .START(START), .data_register(data_register),
    .register_add(register_add), .SENSE(SENSE), .ROW(ROW), .COL(COL),
    .READ_EN(READ_EN), .SET_PULSE(SET_PULSE), .RESET_PULSE(RESET_PULSE),
    .BUSY(BUSY), .DONE(DONE), .FAIL(FAIL), .FAIL_MAP(FAIL_MAP)
  );

  always #5 CLK = ~CLK;

  // A cell reads its target once it has received need[c] full pulses, else the inverse.
  assign SENSE = (pc[COL] >= need[COL] * P) ? tgt[COL] : ~tgt[COL];

  function automatic void push(input logic [4:0] row, input logic [4:0] col,
                               input logic rd, input logic st, input logic rs,
                               input logic busy, input logic done, input logic fail,
                               input logic [31:0] fmap, input bit ccol);
    obs_t e;
    e.row = row; e.col = col; e.rd = rd; e.st = st; e.rs = rs;
    e.busy = busy; e.done = done; e.fail = fail; e.fmap = fmap;
    exp_q.push_back(e);
    ccol_q.push_back(ccol);
  endfunction

  function automatic void build_expected(input logic [31:0] data, input logic [4:0] row);
    logic [31:0] map;
    int n;
    map = '0;
    exp_q.delete();
    ccol_q.delete();
    for (int c = 0; c < 32; c++) begin
      n = (need[c] > M) ? M : need[c];
      for (int r = 0; r <= n; r++) begin
        for (int s = 0; s < S; s++) push(row, 5'(c), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, map, 1'b1);
        if (r < n)
          for (int p = 0; p < P; p++) push(row, 5'(c), 1'b0, data[c], ~data[c], 1'b1, 1'b0, 1'b0, map, 1'b1);
      end
      if (need[c] > M) map[c] = 1'b1;
    end
    push(row, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, |map, map, 1'b0);
    push(row, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, |map, map, 1'b0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic observe();
    obs_t a, e;
    bit   cc;
    cyc++;
    a.row = ROW; a.col = COL; a.rd = READ_EN; a.st = SET_PULSE; a.rs = RESET_PULSE;
    a.busy = BUSY; a.done = DONE; a.fail = FAIL; a.fmap = FAIL_MAP;
    checks++;
    if ((SET_PULSE && RESET_PULSE) || ((SET_PULSE || RESET_PULSE) && READ_EN)) begin
      errors++;
      $display("FAIL excl cyc=%0d rd=%b set=%b reset=%b required no overlap",
               cyc, READ_EN, SET_PULSE, RESET_PULSE);
    end
    if (SET_PULSE && !prev_set) begin
      set_bursts++;
      set_col = int'(COL);
    end
    if (RESET_PULSE && !prev_rst) reset_bursts++;
    if (SET_PULSE) set_cyc++;
    prev_set = SET_PULSE;
    prev_rst = RESET_PULSE;
    if (SET_PULSE || RESET_PULSE) pc[COL]++;
    if (DONE) begin
      done_seen++;
      done_idx = cyc;
    end
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      cc = ccol_q.pop_front();
      if (!cc) a.col = e.col;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL trace cyc=%0d actual=%h required=%h (row,col,rd,set,reset,busy,done,fail,map)",
                 cyc, a, e);
      end
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    observe();
    @(posedge CLK);
    #1;
  endtask

  task automatic begin_op(input logic [31:0] data, input logic [4:0] row);
    for (int i = 0; i < 32; i++) pc[i] = 0;
    tgt = data;
    set_bursts = 0; reset_bursts = 0; set_cyc = 0; set_col = -1; done_seen = 0; done_idx = 0;
    START = 1'b1;
    data_register = data;
    register_add = row;
    tick();
    START = 1'b0;
    data_register = $urandom;
    register_add = 5'($urandom);
    build_expected(data, row);
    cyc = 0;
  endtask

  task automatic run_op(input logic [31:0] data, input logic [4:0] row, input bit inject);
    int n;
    begin_op(data, row);
    n = 0;
    while (exp_q.size() > 0 && n < 1000) begin
      START = inject && (n == 37);
      if (inject && n == 37) data_register = ~data;
      tick();
      n++;
    end
    START = 1'b0;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL timeout actual=%0d cycles required completion", n);
      exp_q.delete();
      ccol_q.delete();
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {17'b0, ROW, COL, READ_EN, SET_PULSE, RESET_PULSE, BUSY, DONE}, 32'd0);
    chk({name, "_fail"}, 32'(FAIL), 32'd0);
    chk({name, "_map"}, FAIL_MAP, 32'd0);
  endtask

  initial begin
    int sc, n, r;
    RST = 1'b1; START = 1'b0; data_register = '0; register_add = '0;
    prev_set = 1'b0; prev_rst = 1'b0; cyc = 0;
    for (int i = 0; i < 32; i++) begin need[i] = 0; pc[i] = 0; end
    tgt = '0;
    @(posedge CLK); #1;
    tick();
    chk_all_zero("reset");
    RST = 1'b0;
    tick();

    // All cells already correct.
    run_op(32'hA5A5_5A5A, 5'd9, 1'b0);
    chk("best_done_cycle", done_idx, 32'd65);
    chk("best_done_count", done_seen, 32'd1);
    chk("best_pulses", set_bursts + reset_bursts, 32'd0);
    chk("best_fail", 32'(FAIL), 32'd0);
    chk("best_map", FAIL_MAP, 32'd0);

    // Single weak bit on column 7.
    need[7] = 1;
    run_op(32'h0F0F_F0F0, 5'd3, 1'b0);
    chk("weak_done_cycle", done_idx, 32'd71);
    chk("weak_set_bursts", set_bursts, 32'd1);
    chk("weak_set_cycles", set_cyc, 32'd4);
    chk("weak_set_col", set_col, 32'd7);
    chk("weak_fail", 32'(FAIL), 32'd0);

    // Stuck cell on column 31.
    need[7] = 0; need[31] = 99;
    run_op(32'h8000_0001, 5'd30, 1'b0);
    chk("stuck_done_cycle", done_idx, 32'd83);
    chk("stuck_set_bursts", set_bursts, 32'd3);
    chk("stuck_map", FAIL_MAP, 32'h8000_0000);
    chk("stuck_fail_held", 32'(FAIL), 32'd1);
    tick();
    chk("stuck_fail_held2", 32'(FAIL), 32'd1);

    // RESET polarity on column 0; this START also clears the previous failure.
    need[31] = 0; need[0] = 2;
    run_op(32'hFFFF_FFFE, 5'd17, 1'b0);
    chk("pol_reset_bursts", reset_bursts, 32'd2);
    chk("pol_set_bursts", set_bursts, 32'd0);
    chk("pol_done_cycle", done_idx, 32'd77);
    chk("pol_fail", 32'(FAIL), 32'd0);
    chk("pol_map", FAIL_MAP, 32'd0);

    // START while busy must be ignored.
    need[0] = 0; need[4] = 1; need[12] = 99; need[20] = 2;
    run_op(32'h1357_9BDF, 5'd11, 1'b1);
    chk("busy_start_done_count", done_seen, 32'd1);
    chk("busy_start_map", FAIL_MAP, 32'h0000_1000);
    tick();
    chk("busy_start_idle", 32'(BUSY), 32'd0);

    // Reset during the second cycle of a SET pulse.
    for (int i = 0; i < 32; i++) need[i] = 0;
    need[7] = 1;
    begin_op(32'hFFFF_FFFF, 5'd21);
    sc = 0; n = 0;
    while (1) begin
      @(negedge CLK);
      observe();
      if (SET_PULSE) sc++;
      n++;
      if (sc >= 2 || n >= 200) break;
      @(posedge CLK); #1;
    end
    chk("rst_reached_pulse", 32'(sc), 32'd2);
    RST = 1'b1;
    exp_q.delete();
    ccol_q.delete();
    @(posedge CLK); #1;
    RST = 1'b0;
    chk_all_zero("midreset");
    run_op(32'h0000_0080, 5'd5, 1'b0);
    chk("post_reset_done_cycle", done_idx, 32'd71);

    // Randomized operations.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 32; i++) begin
        r = int'($urandom_range(0, 9));
        need[i] = (r < 6) ? 0 : (r == 6) ? 1 : (r == 7) ? 2 : (r == 8) ? 3 : 99;
      end
      run_op($urandom, 5'($urandom), (k % 2) == 1);
      chk("rand_done_count", done_seen, 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
